uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receiver, 8N1, LSB first, 115200 baud from a 27 MHz clock. Receive
//  counterpart of tx. Synchronises the asynchronous serial input and validates
//  the start bit at mid-bit. Samples each data bit and the stop bit at mid-bit.
//  Presents each received byte with a one-cycle valid strobe to the command
//  parser. A bad stop bit raises a one-cycle frame-error strobe instead.
// PARAMETERS
//  CLKS_PER_BIT  234  clocks per bit (27000000/115200, truncated)
// PORTS
//  clk        in   1  system clock, 27 MHz; single clock domain
//  rst_n      in   1  reset, synchronous, active-low
//  rx         in   1  serial input, asynchronous, idles high
//  data_in    out  8  last good byte received; held until the next good byte
//  rx_valid   out  1  one-cycle pulse: data_in updated this cycle
//  frame_err  out  1  one-cycle pulse: stop bit sampled low, byte dropped
//  rx_state   out  2  FSM state: 0 IDLE, 1 START, 2 DATA, 3 STOP
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk) forces:
//   - state IDLE; clk_count=0; bit_index=0; shift register=0; armed=1
//   - data_in=0; rx_valid=0; frame_err=0; both sync flops =1
//   - Reset mid-frame abandons the byte; no strobe is issued.
//  Synchroniser: two flops, rx -> s1 -> rx_s. All FSM decisions use rx_s only.
//  clk_count is 8 bits; CLKS_PER_BIT must be <=255.
//  IDLE: clk_count=0, bit_index=0.
//   - rx_s=1 -> armed<=1.
//   - rx_s=0 && armed -> START.
//   - rx_s=0 && !armed -> stay in IDLE (line-break guard).
//  START: count up from 0.
//   - At clk_count==CLKS_PER_BIT/2-1 (116), sample rx_s.
//   - rx_s=0 -> DATA, clk_count<=0.
//   - rx_s=1 -> IDLE (glitch reject; no strobe).
//  DATA: count 0..CLKS_PER_BIT-1.
//   - At clk_count==CLKS_PER_BIT-1: shift rx_s in at bit[bit_index].
//   - Same cycle: clk_count<=0, bit_index++.
//   - Leave for STOP after bit 7; bit_index wraps to 0.
//  STOP: at clk_count==CLKS_PER_BIT-1, sample rx_s, then go to IDLE.
//   - rx_s=1: data_in<=shift register, rx_valid=1 for exactly the next cycle.
//   - rx_s=0: frame_err=1 for the next cycle, data_in unchanged, armed<=0.
//   - Both cases leave the FSM at mid-stop-bit, so a start edge that follows
//     immediately is caught.
//  rx_valid and frame_err are mutually exclusive and never high 2 cycles in a row.
//  Latency: rx falling edge -> rx_valid is 2 sync cycles plus about 9.5 bit times.
//   - 117 + 9*234 clocks from START entry, +1 cycle for the registered strobe.
//  Tolerance: mid-bit sampling accepts sender rate error of about +/-4% over a frame.
//  A new start edge arriving while not in IDLE is ignored. No overrun flag:
//   the consumer must take data_in within one byte time (~2340 clocks).
// TESTING
//  1. Send 0xA5 at 234 clk/bit -> one rx_valid pulse, data_in=0xA5,
//     frame_err never asserted, rx_state returns to 0.
//  2. Pulse rx low for 50 clks, then high -> FSM enters START, then IDLE at
//     count 116; no rx_valid or frame_err; data_in unchanged.
//  3. Send 0x3C with stop bit forced 0, after a good 0x11 ->
//     - one frame_err pulse; data_in stays 0x11.
//     - Hold rx low 5000 clks -> no new frame starts.
//     - Release rx, send 0x42 -> rx_valid, data_in=0x42.
//  4. Back-to-back 0x00, 0xFF, 0x55 with zero idle between frames ->
//     three rx_valid pulses in order; data_in = 0x00, 0xFF, 0x55.
//  5. Assert rst_n=0 for 3 clks during bit 4 of 0xC3 ->
//     - all outputs 0, rx_state=0, no strobe.
//     - Next full 0x7E is received correctly.
//  6. Sender at 225 and at 243 clk/bit sending 0x96 -> data_in=0x96 both times,
//     no frame_err.

Source files
------------

// File: rtl/uart_rx_if.sv
// Serial-receive bundle between the UART receiver and its consumer.
// The receiver takes the master side; the consumer drives rx and reads the results.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_in;
  logic       rx_valid;
  logic       frame_err;
  logic [1:0] rx_state;

  modport master (
    input  rx,
    output data_in,
    output rx_valid,
    output frame_err,
    output rx_state
  );

  modport slave (
    output rx,
    input  data_in,
    input  rx_valid,
    input  frame_err,
    input  rx_state
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling after a two-flop synchroniser.
// Emits a one-cycle rx_valid per good byte, or a one-cycle frame_err on a low stop bit.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 234
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);

  localparam logic [7:0] LastCnt = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] MidCnt  = 8'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] clk_count_q, clk_count_d;
  logic [2:0] bit_index_q, bit_index_d;
  logic [7:0] shift_q, shift_d;
  logic       armed_q, armed_d;
  logic [7:0] data_in_q, data_in_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       s1_q, s1_d;
  logic       rx_s_q, rx_s_d;

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    data_in_d   = data_in_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    s1_d        = bus.rx;
    rx_s_d      = s1_q;

    unique case (state_q)
      StIdle: begin
        clk_count_d = 8'd0;
        bit_index_d = 3'd0;
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (clk_count_q == MidCnt) begin
          clk_count_d = 8'd0;
          // A line that is high again at mid-start was only a glitch.
          state_d     = rx_s_q ? StIdle : StData;
        end else begin
          clk_count_d = clk_count_q + 8'd1;
        end
      end

      StData: begin
        if (clk_count_q == LastCnt) begin
          clk_count_d          = 8'd0;
          shift_d[bit_index_q] = rx_s_q;
          bit_index_d          = bit_index_q + 3'd1;
          if (bit_index_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          clk_count_d = clk_count_q + 8'd1;
        end
      end

      StStop: begin
        if (clk_count_q == LastCnt) begin
          clk_count_d = 8'd0;
          state_d     = StIdle;
          if (rx_s_q) begin
            data_in_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            // Disarm so a held-low line break is not taken as a new start bit.
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end else begin
          clk_count_d = clk_count_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      clk_count_q <= 8'd0;
      bit_index_q <= 3'd0;
      shift_q     <= 8'd0;
      armed_q     <= 1'b1;
      data_in_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      s1_q        <= 1'b1;
      rx_s_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      data_in_q   <= data_in_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      s1_q        <= s1_d;
      rx_s_q      <= rx_s_d;
    end
  end

  assign bus.data_in   = data_in_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_state  = state_q;

endmodule
